pll_dyn_ctrl: RTL and testbench

Dynamic-reconfiguration and lock supervisor for the board PLL. It accepts a new divider/duty/phase set through a valid/ready handshake and drives the PLL `dyn_*` inputs. It sequences `pll_rst`, waits for a qualified lock (with timeout and bounded retry), and re-locks automatically on lock loss. It sits directly upstream of the PLL instance and runs on the free-running reference clock, so it keeps running while the PLL outputs are stopped.

---
 rtl/pll_dyn_pkg.sv | 45 ++++
 rtl/pll_dyn_ctrl_if.sv | 58 +++++
 rtl/pll_lock_sync.sv | 21 ++
 rtl/pll_dyn_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_dyn_pkg.sv
// Shared types and reset defaults for the PLL dynamic-reconfiguration controller.
package pll_dyn_pkg;

    localparam int unsigned DIV_W   = 10;
    localparam int unsigned PHASE_W = 13;
    localparam int unsigned LOSS_W  = 8;

    localparam logic [DIV_W-1:0]   DYN_IDIV_DEF  = DIV_W'(2);
    localparam logic [DIV_W-1:0]   DYN_FDIV_DEF  = DIV_W'(32);
    localparam logic [DIV_W-1:0]   DYN_ODIV_DEF  = DIV_W'(100);
    localparam logic [DIV_W-1:0]   DYN_DUTY_DEF  = DIV_W'(100);
    localparam logic [PHASE_W-1:0] DYN_PHASE_DEF = PHASE_W'(16);

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        WAIT_LOCK,
        STABLE,
        FAIL
    } pll_state_e;

    // One complete divider/duty/phase set as presented to the PLL
    typedef struct packed {
        logic [DIV_W-1:0]   idiv;
        logic [DIV_W-1:0]   fdiv;
        logic [DIV_W-1:0]   odiv0;
        logic [DIV_W-1:0]   odiv1;
        logic [DIV_W-1:0]   duty0;
        logic [DIV_W-1:0]   duty1;
        logic [PHASE_W-1:0] phase0;
        logic [PHASE_W-1:0] phase1;
    } pll_cfg_t;

    localparam pll_cfg_t PLL_CFG_DEF = '{
        idiv:   DYN_IDIV_DEF,
        fdiv:   DYN_FDIV_DEF,
        odiv0:  DYN_ODIV_DEF,
        odiv1:  DYN_ODIV_DEF,
        duty0:  DYN_DUTY_DEF,
        duty1:  DYN_DUTY_DEF,
        phase0: DYN_PHASE_DEF,
        phase1: DYN_PHASE_DEF
    };

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Configuration handshake, PLL dyn_* bus and lock/status signals of pll_dyn_ctrl.
// loss_cnt exists only when PLL_DYN_LOSS_CNT_EN is defined.
interface pll_dyn_ctrl_if;
    import pll_dyn_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [DIV_W-1:0]   cfg_idiv;
    logic [DIV_W-1:0]   cfg_fdiv;
    logic [DIV_W-1:0]   cfg_odiv0;
    logic [DIV_W-1:0]   cfg_odiv1;
    logic [DIV_W-1:0]   cfg_duty0;
    logic [DIV_W-1:0]   cfg_duty1;
    logic [PHASE_W-1:0] cfg_phase0;
    logic [PHASE_W-1:0] cfg_phase1;

    logic [DIV_W-1:0]   dyn_idiv;
    logic [DIV_W-1:0]   dyn_fdiv;
    logic [DIV_W-1:0]   dyn_odiv0;
    logic [DIV_W-1:0]   dyn_odiv1;
    logic [DIV_W-1:0]   dyn_duty0;
    logic [DIV_W-1:0]   dyn_duty1;
    logic [PHASE_W-1:0] dyn_phase0;
    logic [PHASE_W-1:0] dyn_phase1;

    logic               pll_rst;
    logic               pll_lock;
    logic               locked;
    logic               done;
    logic               err;
`ifdef PLL_DYN_LOSS_CNT_EN
    logic [LOSS_W-1:0]  loss_cnt;
`endif

    // Configuration source plus the PLL itself
    modport master (
        output cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_odiv1,
               cfg_duty0, cfg_duty1, cfg_phase0, cfg_phase1, pll_lock,
        input  cfg_ready, dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1,
               dyn_duty0, dyn_duty1, dyn_phase0, dyn_phase1,
               pll_rst, locked, done, err
`ifdef PLL_DYN_LOSS_CNT_EN
        , input loss_cnt
`endif
    );

    modport slave (
        input  cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_odiv1,
               cfg_duty0, cfg_duty1, cfg_phase0, cfg_phase1, pll_lock,
        output cfg_ready, dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1,
               dyn_duty0, dyn_duty1, dyn_phase0, dyn_phase1,
               pll_rst, locked, done, err
`ifdef PLL_DYN_LOSS_CNT_EN
        , output loss_cnt
`endif
    );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the reference clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta_q   <= async_in;
            sync_out <= meta_q;
        end
    end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic-reconfiguration and lock supervisor: latches dyn_* settings, sequences pll_rst,
// qualifies lock with timeout/retry and re-locks on loss. PLL_DYN_LOSS_CNT_EN adds loss_cnt.
module pll_dyn_ctrl
    import pll_dyn_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 32,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic          clk,
    input  logic          rst,
    pll_dyn_ctrl_if.slave bus
);

    localparam int unsigned RST_CNT_W = $clog2(RST_CYCLES) + 1;
    localparam int unsigned TO_CNT_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned STB_CNT_W = $clog2(LOCK_STABLE) + 1;
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY) + 1;

    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_CNT_W-1:0] STB_LAST = STB_CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0]   RETRY_MX = RETRY_W'(MAX_RETRY);

    pll_state_e           state_q,    state_d;
    logic [RST_CNT_W-1:0] rst_cnt_q,  rst_cnt_d;
    logic [TO_CNT_W-1:0]  to_cnt_q,   to_cnt_d;
    logic [STB_CNT_W-1:0] stb_cnt_q,  stb_cnt_d;
    logic [RETRY_W-1:0]   retry_q,    retry_d;

    pll_cfg_t             dyn_q,      dyn_d;
    logic                 pll_rst_q,  pll_rst_d;
    logic                 ready_q,    ready_d;
    logic                 locked_q,   locked_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;

    pll_cfg_t             cfg_in;
    logic                 lock_s;
    logic                 accept;
    logic                 lock_lost;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.pll_lock),
        .sync_out (lock_s)
    );

    always_comb begin
        cfg_in = '{
            idiv:   bus.cfg_idiv,
            fdiv:   bus.cfg_fdiv,
            odiv0:  bus.cfg_odiv0,
            odiv1:  bus.cfg_odiv1,
            duty0:  bus.cfg_duty0,
            duty1:  bus.cfg_duty1,
            phase0: bus.cfg_phase0,
            phase1: bus.cfg_phase1
        };
    end

    // ready_q is only ever high in IDLE/FAIL, so it alone qualifies the handshake
    assign accept    = bus.cfg_valid & ready_q;
    assign lock_lost = (state_q == IDLE) & locked_q & ~lock_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PRST;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            retry_q   <= '0;
            dyn_q     <= PLL_CFG_DEF;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            retry_q   <= retry_d;
            dyn_q     <= dyn_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            locked_q  <= locked_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state and sequencing counters
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        retry_d   = retry_q;

        unique case (state_q)
            IDLE: begin
                if (accept || lock_lost) begin
                    state_d   = PRST;
                    rst_cnt_d = '0;
                    retry_d   = '0;
                end
            end
            PRST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = WAIT_LOCK;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d   = STABLE;
                    stb_cnt_d = '0;
                end else if (to_cnt_q >= TO_LAST) begin
                    if (retry_q < RETRY_MX) begin
                        state_d   = PRST;
                        rst_cnt_d = '0;
                        retry_d   = retry_q + RETRY_W'(1);
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                end
            end
            STABLE: begin
                // Timeout counter is kept so a chattering lock still runs out of time
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d = IDLE;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_CNT_W'(1);
                end
            end
            FAIL: begin
                if (accept) begin
                    state_d   = PRST;
                    rst_cnt_d = '0;
                    retry_d   = '0;
                end
            end
            default: begin
                state_d   = PRST;
                rst_cnt_d = '0;
                retry_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        dyn_d     = dyn_q;
        pll_rst_d = 1'b0;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        locked_d  = 1'b0;
        err_d     = 1'b0;

        if (accept) begin
            dyn_d = cfg_in;
        end
        pll_rst_d = (state_d == PRST) || (state_d == FAIL);
        ready_d   = (state_d == IDLE) || (state_d == FAIL);
        done_d    = (state_q == STABLE) && (state_d == IDLE);
        locked_d  = done_d || (locked_q && (state_d == IDLE));
        err_d     = (state_d == FAIL);
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.dyn_idiv   = dyn_q.idiv;
    assign bus.dyn_fdiv   = dyn_q.fdiv;
    assign bus.dyn_odiv0  = dyn_q.odiv0;
    assign bus.dyn_odiv1  = dyn_q.odiv1;
    assign bus.dyn_duty0  = dyn_q.duty0;
    assign bus.dyn_duty1  = dyn_q.duty1;
    assign bus.dyn_phase0 = dyn_q.phase0;
    assign bus.dyn_phase1 = dyn_q.phase1;
    assign bus.pll_rst    = pll_rst_q;
    assign bus.locked     = locked_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

`ifdef PLL_DYN_LOSS_CNT_EN
    logic [LOSS_W-1:0] loss_q;

    // Saturating count of lock losses seen while locked in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (lock_lost && (loss_q != {LOSS_W{1'b1}})) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign bus.loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed self-checking bench for pll_dyn_ctrl with a simple PLL lock model.
// loss_cnt checks are compiled in only with PLL_DYN_LOSS_CNT_EN.
module tb_pll_dyn_ctrl;

    localparam int unsigned RST_CYC = 32;
    localparam int unsigned TMO     = 1000;
    localparam int unsigned STB     = 64;
    localparam int unsigned RETRY   = 3;

    logic clk_tb;
    logic rst;

    int n_chk  = 0;
    int n_err  = 0;

    // PLL model knobs
    bit          model_en   = 1'b1;
    bit          force_low  = 1'b0;
    int unsigned lock_delay = 500;
    int unsigned pll_cnt    = 0;
    bit          rdy_seen;

    pll_dyn_ctrl_if bus ();

    pll_dyn_ctrl #(
        .RST_CYCLES   (RST_CYC),
        .LOCK_TIMEOUT (TMO),
        .LOCK_STABLE  (STB),
        .MAX_RETRY    (RETRY)
    ) dut (
        .clk (clk_tb),
        .rst (rst),
        .bus (bus)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    // Lock model: lock rises lock_delay cycles after pll_rst falls
    always @(posedge clk_tb) begin
        if (bus.pll_rst)
            pll_cnt <= 0;
        else if (pll_cnt < 100000)
            pll_cnt <= pll_cnt + 1;
    end
    assign bus.pll_lock = model_en && !force_low && !bus.pll_rst && (pll_cnt >= lock_delay);

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.done;
            1:       return !bus.pll_rst;
            2:       return bus.err;
            3:       return !bus.locked;
            default: return bus.cfg_ready;
        endcase
    endfunction

    // Count edges until the selected condition holds, giving up after budget
    task automatic wait_for(input int sel, input int budget, output int n);
        n = 0;
        while (!cond(sel) && n < budget) begin
            rdy_seen = rdy_seen | bus.cfg_ready;
            tick();
            n++;
        end
    endtask

    task automatic handshake(input int odiv0, input int odiv1, input int duty0);
        int n;
        bus.cfg_idiv   = 10'd2;
        bus.cfg_fdiv   = 10'd32;
        bus.cfg_odiv0  = 10'(odiv0);
        bus.cfg_odiv1  = 10'(odiv1);
        bus.cfg_duty0  = 10'(duty0);
        bus.cfg_duty1  = 10'd100;
        bus.cfg_phase0 = 13'd16;
        bus.cfg_phase1 = 13'd16;
        wait_for(4, 20, n);
        check("hs_ready", int'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int falls;
        int bad;
        bit prev;

        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_idiv   = '0;
        bus.cfg_fdiv   = '0;
        bus.cfg_odiv0  = '0;
        bus.cfg_odiv1  = '0;
        bus.cfg_duty0  = '0;
        bus.cfg_duty1  = '0;
        bus.cfg_phase0 = '0;
        bus.cfg_phase1 = '0;
        repeat (3) tick();

        // Reset values
        check("rst_pll_rst",   int'(bus.pll_rst), 1);
        check("rst_cfg_ready", int'(bus.cfg_ready), 0);
        check("rst_locked",    int'(bus.locked), 0);
        check("rst_done",      int'(bus.done), 0);
        check("rst_err",       int'(bus.err), 0);
        check("rst_idiv",      int'(bus.dyn_idiv), 2);
        check("rst_fdiv",      int'(bus.dyn_fdiv), 32);
        check("rst_odiv0",     int'(bus.dyn_odiv0), 100);
        check("rst_odiv1",     int'(bus.dyn_odiv1), 100);
        check("rst_duty0",     int'(bus.dyn_duty0), 100);
        check("rst_duty1",     int'(bus.dyn_duty1), 100);
        check("rst_phase0",    int'(bus.dyn_phase0), 16);
        check("rst_phase1",    int'(bus.dyn_phase1), 16);
`ifdef PLL_DYN_LOSS_CNT_EN
        check("rst_loss_cnt",  int'(bus.loss_cnt), 0);
`endif

        // Bring-up: lock appears 500 cycles after pll_rst falls
        @(negedge clk_tb);
        rst = 1'b0;
        wait_for(1, 100, n);
        check("bringup_rst_len", n, 32);
        wait_for(0, 2000, n);
        check("bringup_done_lat", n, 500 + 2 + 1 + 64);
        check("bringup_locked", int'(bus.locked), 1);
        check("bringup_odiv0", int'(bus.dyn_odiv0), 100);
        check("bringup_ready", int'(bus.cfg_ready), 1);
        tick();
        check("bringup_done_pulse", int'(bus.done), 0);
        check("bringup_locked_hold", int'(bus.locked), 1);

        // Reconfigure with an immediately locking PLL: minimum latency
        lock_delay = 0;
        handshake(200, 100, 200);
        check("recfg_odiv0", int'(bus.dyn_odiv0), 200);
        check("recfg_duty0", int'(bus.dyn_duty0), 200);
        check("recfg_odiv1", int'(bus.dyn_odiv1), 100);
        check("recfg_pll_rst", int'(bus.pll_rst), 1);
        check("recfg_ready", int'(bus.cfg_ready), 0);
        check("recfg_locked", int'(bus.locked), 0);
        rdy_seen = 1'b0;
        wait_for(1, 100, n);
        check("recfg_rst_len", n, 32);
        wait_for(0, 300, n);
        check("recfg_done_lat", n, 2 + 64 + 1);
        check("recfg_ready_busy", int'(rdy_seen), 0);
        check("recfg_locked_up", int'(bus.locked), 1);

        // Lock glitch: 40 cycles up, 10 down, then steady
        handshake(200, 150, 200);
        wait_for(1, 100, n);
        check("glitch_rst_len", n, 32);
        repeat (40) tick();
        force_low = 1'b1;
        repeat (10) tick();
        force_low = 1'b0;
        wait_for(0, 300, n);
        check("glitch_done_lat", n, 2 + 1 + 64);
        check("glitch_odiv1", int'(bus.dyn_odiv1), 150);

        // Timeout and retry: PLL never locks
        model_en = 1'b0;
        handshake(300, 150, 200);
        n = 0;
        falls = 0;
        while (!bus.err && n < 6000) begin
            prev = bus.pll_rst;
            tick();
            n++;
            if (prev && !bus.pll_rst) falls++;
        end
        check("tmo_cycles", n, 4 * (32 + 1000));
        check("tmo_rst_pulses", falls, 4);
        check("tmo_err", int'(bus.err), 1);
        check("tmo_ready", int'(bus.cfg_ready), 1);
        check("tmo_pll_held", int'(bus.pll_rst), 1);
        repeat (5) tick();
        check("tmo_err_sticky", int'(bus.err), 1);

        model_en   = 1'b1;
        lock_delay = 5;
        handshake(300, 150, 200);
        check("clr_err", int'(bus.err), 0);
        check("clr_pll_rst", int'(bus.pll_rst), 1);
        check("clr_odiv0", int'(bus.dyn_odiv0), 300);
        wait_for(1, 100, n);
        check("clr_rst_len", n, 32);
        wait_for(0, 300, n);
        check("clr_done_lat", n, 5 + 2 + 1 + 64);

        // Lock loss while locked in IDLE
        force_low = 1'b1;
        wait_for(3, 10, n);
        check("loss_locked_fall", n, 3);
`ifdef PLL_DYN_LOSS_CNT_EN
        check("loss_cnt_one", int'(bus.loss_cnt), 1);
`endif
        force_low = 1'b0;
        check("loss_relock_rst", int'(bus.pll_rst), 1);
        check("loss_odiv0_kept", int'(bus.dyn_odiv0), 300);
        wait_for(0, 300, n);
        check("loss_relock_lat", n, 32 + 72);
        bad = 0;
        for (int i = 0; i < 299; i++) begin
            force_low = 1'b1;
            wait_for(3, 10, n);
            if (n != 3) bad++;
            force_low = 1'b0;
            wait_for(0, 300, n);
            if (n != 104) bad++;
        end
        check("loss_loop_bad", bad, 0);
        check("loss_loop_locked", int'(bus.locked), 1);
        check("loss_loop_odiv1", int'(bus.dyn_odiv1), 150);
`ifdef PLL_DYN_LOSS_CNT_EN
        check("loss_cnt_sat", int'(bus.loss_cnt), 255);
`endif

        // Reset asserted during WAIT_LOCK
        force_low = 1'b1;
        wait_for(3, 10, n);
        wait_for(1, 100, n);
        check("midrst_rst_len", n, 32);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("midrst_pll_rst", int'(bus.pll_rst), 1);
        check("midrst_ready", int'(bus.cfg_ready), 0);
        check("midrst_locked", int'(bus.locked), 0);
        check("midrst_err", int'(bus.err), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_odiv0", int'(bus.dyn_odiv0), 100);
        check("midrst_odiv1", int'(bus.dyn_odiv1), 100);
        check("midrst_duty0", int'(bus.dyn_duty0), 100);
`ifdef PLL_DYN_LOSS_CNT_EN
        check("midrst_loss_cnt", int'(bus.loss_cnt), 0);
`endif
        force_low = 1'b0;
        @(negedge clk_tb);
        rst = 1'b0;
        wait_for(1, 100, n);
        check("midrst_rst_len2", n, 32);
        wait_for(0, 300, n);
        check("midrst_done_lat", n, 72);
        check("midrst_locked_up", int'(bus.locked), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
